mux_pipe_nxw: RTL and testbench
===============================

// Module: mux_pipe_nxw
// PURPOSE
//   N-way, WIDTH-bit select mux with a built-in STAGES-deep pipeline register chain.
//   Generalises the fixed 2x32 combinational mux into a parametrised, stallable,
//   flushable datapath select. Intended for forwarding and ALU-operand selection
//   where the selected value must cross one or more pipeline boundaries.
//   Also counts delivered valid beats, for the performance counters.
// PARAMETERS
//   N       4   number of input lanes, >=2
//   WIDTH   32  bits per lane
//   STAGES  1   register stages between selection and output, 1..4
//   CNT_W   16  width of the delivered-beat counter
//   SEL_W   derived, $clog2(N); not overridable
// PORTS
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous reset, active-high
//   stall      in   1          hold all stages; no advance
//   flush      in   1          invalidate every stage
//   in_valid   in   1          the current select/data beat is valid
//   sel        in   SEL_W      lane index; lane k = in_data[k*WIDTH +: WIDTH]
//   in_data    in   N*WIDTH    flattened lanes, lane 0 in the LSBs
//   out_data   out  WIDTH      selected data, STAGES cycles later
//   out_valid  out  1          out_data holds a valid beat
//   out_err    out  1          the beat was launched with sel >= N
//   beat_cnt   out  CNT_W      number of valid beats delivered at the output
// BEHAVIOUR
//   - Reset is synchronous and active-high, and clk is the only clock. Reset affects only the registers.
//   - While rst=1 at an edge, all stages load data=0, valid=0 and err=0, and beat_cnt loads 0.
//     The same cycle therefore sees out_data=0, out_valid=0, out_err=0 and beat_cnt=0.
//   - Selection at stage 0 is combinational:
//       sel<N:   d = lane[sel], e = 0
//       sel>=N:  d = 0, e = 1 (only possible when N is not a power of 2)
//   - Bubble rule: when in_valid=0, stage 0 loads data=0 and err=0, so bubbles are all-zero.
//   - Priority at each edge, highest first:
//       1. rst
//       2. flush
//       3. stall
//       4. advance
//   - flush: every stage loads valid=0, data=0 and err=0, and in-flight beats are discarded.
//     flush wins over a simultaneous stall. The input beat in the flush cycle is also dropped.
//   - stall (without flush): every stage, and beat_cnt, holds its value. The input beat
//     is not captured; upstream must hold it.
//   - advance: stage i+1 takes stage i, and stage 0 takes {in_valid, d, e&in_valid}.
//   - Latency: a beat accepted at edge t appears at the outputs after edge t+STAGES-1,
//     plus any stalled edges. There is exactly one accepted beat per non-stalled,
//     non-flushed edge, with no loss or duplication.
//   - Outputs are driven directly from the last stage register, with no combinational input->output path.
//   - beat_cnt increments by 1 on each advancing edge where the last stage's valid is 1
//     (the beat is retired). It wraps modulo 2^CNT_W and does not saturate.
//     It does not count on flush, stall or rst edges.
//   - A flush or rst mid-stream takes effect at the next edge. The beat that was being
//     retired at that edge is not counted.
//   - The X/Z value of sel when in_valid=0 has no effect on state.
// TESTING (N=4, WIDTH=32, STAGES=2, CNT_W=4 unless noted)
//   T1 reset: hold rst=1 for 2 edges with random inputs, including stall and flush
//      -> out_data=0, out_valid=0, out_err=0, beat_cnt=0.
//   T2 latency and select: lane2=32'hDEADBEEF, sel=2, in_valid=1 for 1 cycle at edge t
//      -> after edge t+1, out_data=32'hDEADBEEF and out_valid=1; one cycle later out_valid=0;
//      beat_cnt=1.
//   T3 stall: launch beats A, B and C on consecutive edges, then stall=1 for 3 edges
//      after A is visible -> A holds for 4 cycles, then B and C follow in order,
//      and beat_cnt=3.
//   T4 flush+stall: with 2 beats in flight, assert flush=1 and stall=1 together
//      -> after the next edge out_valid=0 and out_data=0; beat_cnt is unchanged;
//      neither beat ever appears.
//   T5 range (N=3): sel=3, in_valid=1 -> out_data=0 and out_err=1 after the latency.
//      Then sel=1 -> out_err=0.
//   T6 counter wrap: stream 17 back-to-back valid beats -> beat_cnt=4'd1 after the last retires.
//      Repeat with STAGES=1 and STAGES=4 to check latency scaling.

Source files
------------

// File: rtl/mux_pipe_nxw.sv
// mux_pipe_nxw: N-way, WIDTH-bit select mux followed by a STAGES-deep
// stallable, flushable register chain, plus a counter of retired valid beats.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   stall      hold every stage and the beat counter
//   flush      invalidate every stage (wins over stall)
//   in_valid   current sel/in_data beat is valid
//   sel        lane index, lane k = in_data[k*WIDTH +: WIDTH]
//   in_data    flattened lanes, lane 0 in the LSBs
//   out_data   selected data, STAGES cycles after launch
//   out_valid  out_data holds a valid beat
//   out_err    beat was launched with sel >= N
//   beat_cnt   valid beats retired from the last stage, wraps
module mux_pipe_nxw #(
   parameter int unsigned N      = 4,
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 1,
   parameter int unsigned CNT_W  = 16,
   localparam int unsigned SEL_W = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 in_valid,
   input  logic [SEL_W-1:0]     sel,
   input  logic [N*WIDTH-1:0]   in_data,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   output logic                 out_err,
   output logic [CNT_W-1:0]     beat_cnt
);

   typedef struct packed {
      logic             valid;
      logic             err;
      logic [WIDTH-1:0] data;
   } stage_t;

   localparam int unsigned STG_W  = $bits(stage_t);
   localparam int unsigned PIPE_W = STAGES * STG_W;

   logic [N-1:0][WIDTH-1:0] lanes_c;
   stage_t                  stage0_c;
   stage_t                  last_c;
   logic [PIPE_W-1:0]       pipe_q;

   assign lanes_c = in_data;

   // Stage-0 selection; bubbles and out-of-range lanes carry zero data.
   always_comb begin
      stage0_c = '0;
      if (in_valid) begin
         stage0_c.valid = 1'b1;
         if (32'(sel) < N) begin
            stage0_c.data = lanes_c[sel];
         end else begin
            stage0_c.err = 1'b1;
         end
      end
   end

   // Stage 0 sits in the LSBs; the oldest stage occupies the top slot.
   assign last_c = stage_t'(pipe_q[PIPE_W-1 -: STG_W]);

   // Pipeline shift and retirement counter; rst > flush > stall > advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_q   <= '0;
         beat_cnt <= '0;
      end else if (flush) begin
         pipe_q   <= '0;
      end else if (!stall) begin
         // Shifting by one stage drops the retiring beat off the top.
         pipe_q <= PIPE_W'({pipe_q, stage0_c});
         if (last_c.valid) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
         end
      end
   end

   assign out_data  = last_c.data;
   assign out_valid = last_c.valid;
   assign out_err   = last_c.err;

endmodule

// File: tb/tb_mux_pipe_nxw.sv
// tb_mux_pipe_nxw: drives four mux_pipe_nxw instances (N/STAGES variants)
// from one shared stimulus and checks them against a queue-based model.
//
// Instances: 0: N=4 STAGES=2 | 1: N=3 STAGES=2 | 2: N=4 STAGES=1 | 3: N=4 STAGES=4
// All use WIDTH=32 and CNT_W=4.
module tb_mux_pipe_nxw;

   localparam int unsigned NI = 4;
   localparam int STG [NI] = '{2, 2, 1, 4};
   localparam int NL  [NI] = '{4, 3, 4, 4};

   typedef struct {
      logic        v;
      logic        e;
      logic [31:0] d;
   } beat_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         stall;
   logic         flush;
   logic         in_valid;
   logic [1:0]   sel;
   logic [127:0] in_data;

   logic [31:0]  od [NI];
   logic         ov [NI];
   logic         oe [NI];
   logic [3:0]   bc [NI];

   beat_t        mq [NI][$];
   int unsigned  mcnt [NI];
   bit           model_live = 1'b0;

   int           errors = 0;
   int           checks = 0;

   always #5 clk = ~clk;

   mux_pipe_nxw #(.N(4), .WIDTH(32), .STAGES(2), .CNT_W(4)) u0 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
      .sel(sel), .in_data(in_data), .out_data(od[0]), .out_valid(ov[0]),
      .out_err(oe[0]), .beat_cnt(bc[0]));

   mux_pipe_nxw #(.N(3), .WIDTH(32), .STAGES(2), .CNT_W(4)) u1 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
      .sel(sel), .in_data(in_data[95:0]), .out_data(od[1]), .out_valid(ov[1]),
      .out_err(oe[1]), .beat_cnt(bc[1]));

   mux_pipe_nxw #(.N(4), .WIDTH(32), .STAGES(1), .CNT_W(4)) u2 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
      .sel(sel), .in_data(in_data), .out_data(od[2]), .out_valid(ov[2]),
      .out_err(oe[2]), .beat_cnt(bc[2]));

   mux_pipe_nxw #(.N(4), .WIDTH(32), .STAGES(4), .CNT_W(4)) u3 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
      .sel(sel), .in_data(in_data), .out_data(od[3]), .out_valid(ov[3]),
      .out_err(oe[3]), .beat_cnt(bc[3]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // The beat an instance with nl lanes would launch from the current inputs.
   function automatic beat_t launch(input int nl);
      beat_t b;
      logic [3:0][31:0] lanes;
      lanes = in_data;
      b.v = 1'b0;
      b.e = 1'b0;
      b.d = '0;
      if (in_valid) begin
         b.v = 1'b1;
         if (int'(sel) < nl) b.d = lanes[sel];
         else                b.e = 1'b1;
      end
      return b;
   endfunction

   function automatic beat_t empty_beat();
      beat_t b;
      b.v = 1'b0;
      b.e = 1'b0;
      b.d = '0;
      return b;
   endfunction

   // One clock: update the model at the edge, then compare every instance.
   task automatic tick();
      beat_t ret;
      @(posedge clk);
      for (int i = 0; i < int'(NI); i++) begin
         if (rst || flush) begin
            mq[i].delete();
            for (int s = 0; s < STG[i]; s++) mq[i].push_back(empty_beat());
            if (rst) mcnt[i] = 0;
         end else if (!stall) begin
            ret = mq[i].pop_back();
            if (ret.v) mcnt[i] = (mcnt[i] + 1) % 16;
            mq[i].push_front(launch(NL[i]));
         end
      end
      if (rst) model_live = 1'b1;
      #1;
      if (model_live) begin
         for (int i = 0; i < int'(NI); i++) begin
            ret = mq[i][$];
            chk($sformatf("model out_valid[%0d]", i), 32'(ov[i]), 32'(ret.v));
            chk($sformatf("model out_data[%0d]", i), od[i], ret.d);
            chk($sformatf("model out_err[%0d]", i), 32'(oe[i]), 32'(ret.e));
            chk($sformatf("model beat_cnt[%0d]", i), 32'(bc[i]), mcnt[i]);
         end
      end
   endtask

   task automatic idle();
      rst = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; sel = 2'd0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      idle();
      in_data = '0;

      // T1: reset held for two edges while other inputs toggle randomly
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         stall    = 1'($urandom_range(0, 1));
         flush    = 1'($urandom_range(0, 1));
         in_valid = 1'($urandom_range(0, 1));
         sel      = 2'($urandom_range(0, 3));
         in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
         tick();
      end
      for (int i = 0; i < int'(NI); i++) begin
         chk($sformatf("t1 out_data[%0d]", i), od[i], 32'h0);
         chk($sformatf("t1 out_valid[%0d]", i), 32'(ov[i]), 32'h0);
         chk($sformatf("t1 out_err[%0d]", i), 32'(oe[i]), 32'h0);
         chk($sformatf("t1 beat_cnt[%0d]", i), 32'(bc[i]), 32'h0);
      end

      // T2: latency and lane select on the STAGES=2 instance
      do_reset();
      in_data = {$urandom(), 32'hDEADBEEF, $urandom(), $urandom()};
      sel = 2'd2; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk("t2 out_data", od[0], 32'hDEADBEEF);
      chk("t2 out_valid", 32'(ov[0]), 32'h1);
      tick();
      chk("t2 out_valid drop", 32'(ov[0]), 32'h0);
      chk("t2 beat_cnt", 32'(bc[0]), 32'h1);

      // T3: stall holds A for four cycles, then B and C in order
      do_reset();
      in_data = {32'hCCCC_0003, 32'h0, 32'hBBBB_0002, 32'hAAAA_0001};
      in_valid = 1'b1; sel = 2'd0;
      tick();
      sel = 2'd1;
      tick();
      chk("t3 A visible", od[0], 32'hAAAA_0001);
      sel = 2'd3; stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t3 A held", od[0], 32'hAAAA_0001);
         chk("t3 A held valid", 32'(ov[0]), 32'h1);
      end
      stall = 1'b0;
      tick();
      chk("t3 B", od[0], 32'hBBBB_0002);
      chk("t3 cnt after A", 32'(bc[0]), 32'h1);
      in_valid = 1'b0;
      tick();
      chk("t3 C", od[0], 32'hCCCC_0003);
      tick();
      chk("t3 drained valid", 32'(ov[0]), 32'h0);
      chk("t3 beat_cnt", 32'(bc[0]), 32'h3);

      // T4: flush together with stall discards everything in flight
      do_reset();
      in_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      in_valid = 1'b1; sel = 2'd0;
      tick();
      sel = 2'd1;
      tick();
      sel = 2'd2; flush = 1'b1; stall = 1'b1;
      tick();
      chk("t4 out_valid", 32'(ov[0]), 32'h0);
      chk("t4 out_data", od[0], 32'h0);
      chk("t4 beat_cnt", 32'(bc[0]), 32'h0);
      idle();
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t4 deep out_valid", 32'(ov[3]), 32'h0);
      end
      chk("t4 deep beat_cnt", 32'(bc[3]), 32'h0);
      chk("t4 beat_cnt final", 32'(bc[0]), 32'h0);

      // T5: out-of-range select on the three-lane instance
      do_reset();
      in_data = {32'hFFFF_FFFF, 32'h0BAD_0BAD, 32'h1234_5678, 32'h0F0F_0F0F};
      in_valid = 1'b1; sel = 2'd3;
      tick();
      sel = 2'd1;
      tick();
      chk("t5 err data", od[1], 32'h0);
      chk("t5 err flag", 32'(oe[1]), 32'h1);
      chk("t5 err valid", 32'(ov[1]), 32'h1);
      in_valid = 1'b0;
      tick();
      chk("t5 lane1 data", od[1], 32'h1234_5678);
      chk("t5 lane1 err", 32'(oe[1]), 32'h0);

      // T6: 17 back-to-back beats wrap the 4-bit counter to 1 at every depth
      do_reset();
      for (int k = 1; k <= 17; k++) begin
         in_valid = 1'b1;
         sel      = 2'($urandom_range(0, 3));
         in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
         tick();
         if (k == 1) begin
            chk("t6 stages1 first valid", 32'(ov[2]), 32'h1);
            chk("t6 stages2 not yet", 32'(ov[0]), 32'h0);
         end
         if (k == 2) chk("t6 stages2 first valid", 32'(ov[0]), 32'h1);
         if (k == 3) chk("t6 stages4 not yet", 32'(ov[3]), 32'h0);
         if (k == 4) chk("t6 stages4 first valid", 32'(ov[3]), 32'h1);
      end
      idle();
      for (int k = 0; k < 4; k++) tick();
      for (int i = 0; i < int'(NI); i++) begin
         chk($sformatf("t6 beat_cnt[%0d]", i), 32'(bc[i]), 32'h1);
      end

      // Randomised traffic with occasional reset, flush and stall
      for (int k = 0; k < 3000; k++) begin
         rst      = ($urandom_range(0, 63) == 0);
         flush    = ($urandom_range(0, 15) == 0);
         stall    = ($urandom_range(0, 7) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         sel      = 2'($urandom_range(0, 3));
         in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
         tick();
      end
      idle();
      for (int k = 0; k < 6; k++) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
